// File: rtl/router_pkg.sv
// Shared NoC types: flit format, flit kinds and the traffic generator FSM states.
package router_pkg;

  localparam int NUM_OF_FLITS = 4;  // flit type encodings, including the empty slot

  typedef enum logic [$clog2(NUM_OF_FLITS)-1:0] {
    NO_FLIT   = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic        valid;
    FLIT_TYPE_t  ftype;
    logic [7:0]  xaddr;
    logic [7:0]  yaddr;
    logic [15:0] data;
    logic [15:0] reserved;
  } FLIT_t;

  localparam int FLIT_SIZE = $bits(FLIT_t);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    BODY = 3'd2,
    TAIL = 3'd3,
    REQ  = 3'd4,
    SEND = 3'd5,
    GAP  = 3'd6,
    DONE = 3'd7
  } TX_STATE_t;

  typedef enum logic {
    OUT    = 1'b0,
    IN_PKT = 1'b1
  } RX_STATE_t;

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO with registered read; the read port outputs zero on cycles without a read.
module sfifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rd_data    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_data    <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end else begin
        rd_data    <= '0;
      end
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// NoC traffic generator: builds packets into an output FIFO, releases them on router grant,
// and checks framing of incoming flits.
module noc_traffic_gen
  import router_pkg::*;
#(
  parameter int MAX_BODY = 8,
  parameter int FIFO_AW  = 4,
  parameter int BL_W     = $clog2(MAX_BODY+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [7:0]      i_dst_x,
  input  logic [7:0]      i_dst_y,
  input  logic [BL_W-1:0] i_body_len,
  input  logic [15:0]     i_num_pkts,
  input  logic [7:0]      i_gap,
  output FLIT_t           o_flit,
  output logic            o_transmit,
  input  logic            i_send,
  output logic            o_done,
  output logic [15:0]     o_tx_count,
  input  FLIT_t           i_flit,
  input  logic            i_rec_req,
  output logic            o_rec_ack,
  output logic [15:0]     o_rx_count,
  output logic            o_rx_err
);

  if ((2**FIFO_AW) < (MAX_BODY+2)) begin : g_depth_check
    $error("noc_traffic_gen: output FIFO cannot hold a maximum-length packet");
  end

  TX_STATE_t       state_reg, state_next;
  RX_STATE_t       rx_state_reg, rx_state_next;
  logic [7:0]      dst_x_reg, dst_y_reg, gap_cnt_reg;
  logic [BL_W-1:0] body_len_reg, body_idx_reg, body_len_clamped;
  logic [15:0]     tx_count_reg, rx_count_reg, tx_count_inc;
  logic            rx_err_reg;
  logic            run_clear, tail_out, run_complete, build_start;
  logic            fifo_wr_en, fifo_rd_en, fifo_empty, flush;
  logic            rx_fire, rx_pkt_done, rx_bad;
  FLIT_t           wr_flit;
  logic [FLIT_SIZE-1:0] fifo_rd_data;
  logic            unused_rx_fields;

  assign body_len_clamped = (i_body_len == '0) ? BL_W'(1) :
                            (i_body_len > BL_W'(MAX_BODY)) ? BL_W'(MAX_BODY) : i_body_len;
  assign run_clear    = (state_reg == IDLE) && i_start;
  assign tail_out     = o_flit.valid && (o_flit.ftype == TAIL_FLIT);
  assign tx_count_inc = tx_count_reg + 16'd1;
  assign run_complete = (i_num_pkts != 16'd0) && (tx_count_inc == i_num_pkts);
  assign build_start  = (state_next == HEAD) && (state_reg != HEAD);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (i_start) state_next = HEAD;
      HEAD: state_next = i_start ? BODY : IDLE;
      BODY: begin
        if (!i_start) state_next = IDLE;
        else if (body_idx_reg == body_len_reg - BL_W'(1)) state_next = TAIL;
      end
      TAIL: state_next = i_start ? REQ : IDLE;
      REQ: begin
        if (!i_start)    state_next = IDLE;
        else if (i_send) state_next = SEND;
      end
      // The packet is finished once its tail has left the FIFO register.
      SEND: begin
        if (tail_out) begin
          if (!i_start)              state_next = IDLE;
          else if (run_complete)     state_next = DONE;
          else if (i_gap == 8'd0)    state_next = HEAD;
          else                       state_next = GAP;
        end
      end
      GAP: begin
        if (!i_start) state_next = IDLE;
        else if ((gap_cnt_reg + 8'd1) >= i_gap) state_next = HEAD;
      end
      DONE: if (!i_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    wr_flit    = '0;
    o_transmit = (state_reg == REQ);
    o_done     = (state_reg == DONE);
    flush      = !i_start && (state_reg inside {HEAD, BODY, TAIL, REQ, GAP});
    case (state_reg)
      HEAD: begin
        fifo_wr_en    = i_start;
        wr_flit.valid = 1'b1;
        wr_flit.ftype = HEAD_FLIT;
        wr_flit.xaddr = dst_x_reg;
        wr_flit.yaddr = dst_y_reg;
      end
      BODY: begin
        fifo_wr_en    = i_start;
        wr_flit.valid = 1'b1;
        wr_flit.ftype = BODY_FLIT;
        wr_flit.data  = {tx_count_reg[7:0], 8'(body_idx_reg)};
      end
      TAIL: begin
        fifo_wr_en       = i_start;
        wr_flit.valid    = 1'b1;
        wr_flit.ftype    = TAIL_FLIT;
        wr_flit.reserved = {8'd0, tx_count_reg[7:0]};
      end
      SEND: fifo_rd_en = !fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_x_reg    <= '0;
      dst_y_reg    <= '0;
      body_len_reg <= BL_W'(1);
      body_idx_reg <= '0;
      gap_cnt_reg  <= '0;
      tx_count_reg <= '0;
    end else begin
      if (build_start) begin
        dst_x_reg <= i_dst_x;
        dst_y_reg <= i_dst_y;
      end
      if (run_clear) body_len_reg <= body_len_clamped;
      body_idx_reg <= (state_reg == BODY) ? body_idx_reg + BL_W'(1) : '0;
      gap_cnt_reg  <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : '0;
      if (run_clear)     tx_count_reg <= '0;
      else if (tail_out) tx_count_reg <= tx_count_inc;
    end
  end

  sfifo #(
    .WIDTH (FLIT_SIZE),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (~(reset | flush)),
    .wr_en   (fifo_wr_en),
    .wr_data (wr_flit),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign o_flit     = FLIT_t'(fifo_rd_data);
  assign o_tx_count = tx_count_reg;

  // Receive checker: a HEAD seen mid-packet is an error but also opens a new packet.
  assign rx_fire = i_rec_req && i_flit.valid;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_pkt_done   = 1'b0;
    rx_bad        = 1'b0;
    if (rx_fire) begin
      unique case (rx_state_reg)
        OUT: begin
          if (i_flit.ftype == HEAD_FLIT) rx_state_next = IN_PKT;
          else                           rx_bad        = 1'b1;
        end
        IN_PKT: begin
          if (i_flit.ftype == TAIL_FLIT) begin
            rx_pkt_done   = 1'b1;
            rx_state_next = OUT;
          end else if (i_flit.ftype != BODY_FLIT) begin
            rx_bad = 1'b1;
          end
        end
        default: rx_state_next = OUT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg <= OUT;
      rx_count_reg <= '0;
      rx_err_reg   <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      if (run_clear) begin
        rx_count_reg <= '0;
        rx_err_reg   <= 1'b0;
      end else begin
        if (rx_pkt_done) rx_count_reg <= rx_count_reg + 16'd1;
        if (rx_bad)      rx_err_reg   <= 1'b1;
      end
    end
  end

  assign o_rx_count = rx_count_reg;
  assign o_rx_err   = rx_err_reg;
  assign o_rec_ack  = 1'b1;
  assign unused_rx_fields = ^{i_flit.xaddr, i_flit.yaddr, i_flit.data, i_flit.reserved};

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: packet build/send, limits, aborts, RX checker, reset.
module tb_noc_traffic_gen;
  import router_pkg::*;

  localparam int BL_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_start, i_send, i_rec_req;
  logic [7:0]      i_dst_x, i_dst_y, i_gap;
  logic [BL_W-1:0] i_body_len;
  logic [15:0]     i_num_pkts;
  FLIT_t           o_flit, i_flit;
  logic            o_transmit, o_done, o_rec_ack, o_rx_err;
  logic [15:0]     o_tx_count, o_rx_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  noc_traffic_gen dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_dst_x    (i_dst_x),
    .i_dst_y    (i_dst_y),
    .i_body_len (i_body_len),
    .i_num_pkts (i_num_pkts),
    .i_gap      (i_gap),
    .o_flit     (o_flit),
    .o_transmit (o_transmit),
    .i_send     (i_send),
    .o_done     (o_done),
    .o_tx_count (o_tx_count),
    .i_flit     (i_flit),
    .i_rec_req  (i_rec_req),
    .o_rec_ack  (o_rec_ack),
    .o_rx_count (o_rx_count),
    .o_rx_err   (o_rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] d, input logic [15:0] r);
    FLIT_t f;
    f = '0;
    f.valid = 1'b1;
    f.ftype = t;
    f.xaddr = x;
    f.yaddr = y;
    f.data = d;
    f.reserved = r;
    return f;
  endfunction

  // Waits for a head on o_flit (the current cycle counts), then follows the packet to its tail.
  task automatic collect(output int nbody, output logic [15:0] first_data, output logic [15:0] last_data,
                         output FLIT_t head, output FLIT_t tail, output int head_cyc,
                         output int tail_cyc, output bit tmo);
    int k;
    nbody = 0; first_data = '0; last_data = '0; head = '0; tail = '0;
    head_cyc = 0; tail_cyc = 0; tmo = 1'b0;
    k = 0;
    while (!(o_flit.valid && o_flit.ftype == HEAD_FLIT) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      tmo = 1'b1;
      return;
    end
    head = o_flit;
    head_cyc = cyc;
    k = 0;
    do begin
      tick();
      k++;
      if (o_flit.valid && o_flit.ftype == BODY_FLIT) begin
        if (nbody == 0) first_data = o_flit.data;
        last_data = o_flit.data;
        nbody++;
      end
    end while (!(o_flit.valid && o_flit.ftype == TAIL_FLIT) && k < 40);
    if (!(o_flit.valid && o_flit.ftype == TAIL_FLIT)) tmo = 1'b1;
    tail = o_flit;
    tail_cyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_send = 1'b0; i_rec_req = 1'b0; i_flit = '0;
    i_dst_x = '0; i_dst_y = '0; i_gap = '0; i_body_len = '0; i_num_pkts = '0;
    tick(); tick();
    n_cmp++; if (o_flit !== FLIT_t'('0)) begin n_bad++; $display("FAIL reset_flit: got %h want 0", o_flit); end
    n_cmp++; if (o_transmit !== 1'b0) begin n_bad++; $display("FAIL reset_transmit: got %b want 0", o_transmit); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_cmp++; if (o_tx_count !== 16'd0) begin n_bad++; $display("FAIL reset_tx_count: got %0d want 0", o_tx_count); end
    n_cmp++; if (o_rx_count !== 16'd0 || o_rx_err !== 1'b0) begin n_bad++; $display("FAIL reset_rx: got cnt=%0d err=%b want 0/0", o_rx_count, o_rx_err); end
    n_cmp++; if (o_rec_ack !== 1'b1) begin n_bad++; $display("FAIL reset_rec_ack: got %b want 1", o_rec_ack); end
    reset = 1'b0;
    tick();
    $display("reset: checked outputs after reset");
  endtask

  task automatic test_single();
    int k;
    FLIT_t exp;
    i_body_len = 4'd2; i_num_pkts = 16'd1; i_dst_x = 8'd1; i_dst_y = 8'd0; i_gap = 8'd0;
    i_send = 1'b0; i_start = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!o_transmit && k < 50);
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL single_req_latency: got %0d want 5", k); end
    tick(); tick(); tick();
    n_cmp++; if (o_transmit !== 1'b1) begin n_bad++; $display("FAIL single_req_hold: got %b want 1", o_transmit); end
    i_send = 1'b1;
    tick();
    i_send = 1'b0;
    tick();
    exp = mk(HEAD_FLIT, 8'd1, 8'd0, 16'h0000, 16'h0000);
    n_cmp++; if (o_flit !== exp) begin n_bad++; $display("FAIL single_head: got %h want %h", o_flit, exp); end
    tick();
    exp = mk(BODY_FLIT, 8'd0, 8'd0, 16'h0000, 16'h0000);
    n_cmp++; if (o_flit !== exp) begin n_bad++; $display("FAIL single_body0: got %h want %h", o_flit, exp); end
    tick();
    exp = mk(BODY_FLIT, 8'd0, 8'd0, 16'h0001, 16'h0000);
    n_cmp++; if (o_flit !== exp) begin n_bad++; $display("FAIL single_body1: got %h want %h", o_flit, exp); end
    tick();
    exp = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0000, 16'h0000);
    n_cmp++; if (o_flit !== exp) begin n_bad++; $display("FAIL single_tail: got %h want %h", o_flit, exp); end
    n_cmp++; if (o_tx_count !== 16'd0) begin n_bad++; $display("FAIL single_count_early: got %0d want 0", o_tx_count); end
    tick();
    n_cmp++; if (o_flit !== FLIT_t'('0)) begin n_bad++; $display("FAIL single_idle_flit: got %h want 0", o_flit); end
    n_cmp++; if (o_tx_count !== 16'd1) begin n_bad++; $display("FAIL single_tx_count: got %0d want 1", o_tx_count); end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", o_done); end
    i_start = 1'b0;
    tick();
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL single_done_clear: got %b want 0", o_done); end
    $display("single: body_len=2 packet sent, tx_count=%0d", o_tx_count);
  endtask

  task automatic test_body_len();
    int lens[2] = '{0, 11};
    int exps[2] = '{1, 8};
    int nb, hc, tc;
    logic [15:0] fd, ld;
    FLIT_t hd, tl;
    bit tmo;
    for (int i = 0; i < 2; i++) begin
      i_body_len = BL_W'(lens[i]); i_num_pkts = 16'd1; i_gap = 8'd0;
      i_dst_x = 8'd3; i_dst_y = 8'd2; i_send = 1'b1; i_start = 1'b1;
      collect(nb, fd, ld, hd, tl, hc, tc, tmo);
      n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL body_len_timeout[%0d]: got timeout want packet", i); end
      n_cmp++; if (nb !== exps[i]) begin n_bad++; $display("FAIL body_len_count[%0d]: got %0d want %0d", i, nb, exps[i]); end
      n_cmp++; if (tc - hc !== exps[i] + 1) begin n_bad++; $display("FAIL body_len_span[%0d]: got %0d want %0d", i, tc - hc, exps[i] + 1); end
      n_cmp++; if (ld !== {8'd0, 8'(exps[i] - 1)}) begin n_bad++; $display("FAIL body_len_last[%0d]: got %h want %h", i, ld, {8'd0, 8'(exps[i] - 1)}); end
      i_start = 1'b0; i_send = 1'b0;
      tick(); tick();
      $display("body_len: request %0d gave %0d body flits", lens[i], nb);
    end
  endtask

  task automatic test_multi();
    int nb, hc, tc, prev_tc;
    logic [15:0] fd, ld;
    FLIT_t hd, tl, exp;
    bit tmo;
    prev_tc = 0;
    i_body_len = 4'd1; i_num_pkts = 16'd3; i_gap = 8'd4;
    i_dst_x = 8'd2; i_dst_y = 8'd3; i_send = 1'b1; i_start = 1'b1;
    exp = mk(HEAD_FLIT, 8'd2, 8'd3, 16'h0000, 16'h0000);
    for (int p = 0; p < 3; p++) begin
      collect(nb, fd, ld, hd, tl, hc, tc, tmo);
      n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL multi_timeout[%0d]: got timeout want packet", p); end
      n_cmp++; if (hd !== exp) begin n_bad++; $display("FAIL multi_head[%0d]: got %h want %h", p, hd, exp); end
      n_cmp++; if (fd !== {8'(p), 8'd0}) begin n_bad++; $display("FAIL multi_body_seq[%0d]: got %h want %h", p, fd, {8'(p), 8'd0}); end
      n_cmp++; if (tl.reserved !== 16'(p)) begin n_bad++; $display("FAIL multi_tail_seq[%0d]: got %h want %h", p, tl.reserved, 16'(p)); end
      if (p > 0) begin
        n_cmp++; if (hc - prev_tc !== 10) begin n_bad++; $display("FAIL multi_gap[%0d]: got %0d want 10", p, hc - prev_tc); end
      end
      prev_tc = tc;
      $display("multi: packet %0d seq body=%h tail=%h", p, fd, tl.reserved);
    end
    n_cmp++; if (o_tx_count !== 16'd2) begin n_bad++; $display("FAIL multi_count_at_tail: got %0d want 2", o_tx_count); end
    tick();
    n_cmp++; if (o_tx_count !== 16'd3) begin n_bad++; $display("FAIL multi_tx_count: got %0d want 3", o_tx_count); end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL multi_done: got %b want 1", o_done); end
    i_start = 1'b0; i_send = 1'b0;
    tick();
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL multi_done_clear: got %b want 0", o_done); end
  endtask

  task automatic test_abort_body();
    bit saw_v, saw_t, tmo;
    int nb, hc, tc;
    logic [15:0] fd, ld;
    FLIT_t hd, tl, exp;
    i_body_len = 4'd4; i_num_pkts = 16'd1; i_gap = 8'd0;
    i_dst_x = 8'd5; i_dst_y = 8'd5; i_send = 1'b0; i_start = 1'b1;
    tick(); tick();
    i_start = 1'b0;
    saw_v = 1'b0; saw_t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_v |= o_flit.valid;
      saw_t |= o_transmit;
    end
    n_cmp++; if (saw_v !== 1'b0) begin n_bad++; $display("FAIL abort_body_flit: got valid flit want none"); end
    n_cmp++; if (saw_t !== 1'b0) begin n_bad++; $display("FAIL abort_body_transmit: got request want none"); end
    n_cmp++; if (dut.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL abort_body_fifo: got empty=%b want 1", dut.fifo_empty); end
    i_body_len = 4'd1; i_dst_x = 8'd6; i_dst_y = 8'd7; i_send = 1'b1; i_start = 1'b1;
    collect(nb, fd, ld, hd, tl, hc, tc, tmo);
    exp = mk(HEAD_FLIT, 8'd6, 8'd7, 16'h0000, 16'h0000);
    n_cmp++; if (tmo !== 1'b0 || hd !== exp) begin n_bad++; $display("FAIL abort_body_next_head: got %h want %h", hd, exp); end
    n_cmp++; if (nb !== 1 || tc - hc !== 2) begin n_bad++; $display("FAIL abort_body_next_len: got %0d/%0d want 1/2", nb, tc - hc); end
    i_start = 1'b0; i_send = 1'b0;
    tick(); tick();
    $display("abort_body: aborted build left no flits, next packet %0d body flits", nb);
  endtask

  task automatic test_abort_send();
    int k, nb, hc, tc;
    logic [15:0] fd, ld;
    FLIT_t hd, tl;
    bit tmo, saw_v;
    i_body_len = 4'd3; i_num_pkts = 16'd0; i_gap = 8'd0;
    i_dst_x = 8'd1; i_dst_y = 8'd1; i_send = 1'b1; i_start = 1'b1;
    k = 0;
    while (!(o_flit.valid && o_flit.ftype == HEAD_FLIT) && k < 50) begin tick(); k++; end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL abort_send_head: got no head want head"); end
    i_start = 1'b0;
    collect(nb, fd, ld, hd, tl, hc, tc, tmo);
    n_cmp++; if (tmo !== 1'b0 || nb !== 3) begin n_bad++; $display("FAIL abort_send_drain: got %0d body tmo=%b want 3", nb, tmo); end
    n_cmp++; if (tc - hc !== 4) begin n_bad++; $display("FAIL abort_send_span: got %0d want 4", tc - hc); end
    tick();
    n_cmp++; if (o_tx_count !== 16'd1) begin n_bad++; $display("FAIL abort_send_count: got %0d want 1", o_tx_count); end
    saw_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_v |= o_flit.valid | o_transmit;
    end
    n_cmp++; if (saw_v !== 1'b0) begin n_bad++; $display("FAIL abort_send_idle: got activity want idle"); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL abort_send_done: got %b want 0", o_done); end
    i_send = 1'b0;
    $display("abort_send: drained %0d body flits then idle", nb);
  endtask

  task automatic test_rx();
    i_rec_req = 1'b1; i_flit = mk(HEAD_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    i_flit = mk(BODY_FLIT, 8'd0, 8'd0, 16'h1234, 16'h0); tick();
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    i_rec_req = 1'b0;
    n_cmp++; if (o_rx_count !== 16'd1) begin n_bad++; $display("FAIL rx_count_one: got %0d want 1", o_rx_count); end
    n_cmp++; if (o_rx_err !== 1'b0) begin n_bad++; $display("FAIL rx_err_clean: got %b want 0", o_rx_err); end
    i_rec_req = 1'b1; i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); i_flit.valid = 1'b0; tick();
    i_rec_req = 1'b0; i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    n_cmp++; if (o_rx_err !== 1'b0) begin n_bad++; $display("FAIL rx_ignore_invalid: got %b want 0", o_rx_err); end
    i_rec_req = 1'b1; tick();
    i_rec_req = 1'b0; i_flit = '0;
    n_cmp++; if (o_rx_err !== 1'b1) begin n_bad++; $display("FAIL rx_lone_tail: got %b want 1", o_rx_err); end
    n_cmp++; if (o_rx_count !== 16'd1) begin n_bad++; $display("FAIL rx_lone_tail_count: got %0d want 1", o_rx_count); end
    tick(); tick(); tick();
    n_cmp++; if (o_rx_err !== 1'b1) begin n_bad++; $display("FAIL rx_err_sticky: got %b want 1", o_rx_err); end
    i_rec_req = 1'b1; i_flit = mk(HEAD_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    tick();
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    i_rec_req = 1'b0; i_flit = '0;
    n_cmp++; if (o_rx_count !== 16'd2) begin n_bad++; $display("FAIL rx_head_restart: got %0d want 2", o_rx_count); end
    i_body_len = 4'd1; i_num_pkts = 16'd1; i_send = 1'b0; i_start = 1'b1;
    tick();
    n_cmp++; if (o_rx_err !== 1'b0 || o_rx_count !== 16'd0) begin n_bad++; $display("FAIL rx_start_clear: got err=%b cnt=%0d want 0/0", o_rx_err, o_rx_count); end
    i_start = 1'b0;
    tick();
    $display("rx: framing checks done, rx_count=%0d err=%b", o_rx_count, o_rx_err);
  endtask

  task automatic test_reset_mid_send();
    int k, nb, hc, tc;
    logic [15:0] fd, ld;
    FLIT_t hd, tl, exp;
    bit tmo;
    i_body_len = 4'd4; i_num_pkts = 16'd3; i_gap = 8'd0;
    i_dst_x = 8'd9; i_dst_y = 8'd8; i_send = 1'b1; i_start = 1'b1;
    collect(nb, fd, ld, hd, tl, hc, tc, tmo);
    i_rec_req = 1'b1; i_flit = mk(HEAD_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, 16'h0, 16'h0); tick();
    i_rec_req = 1'b0; i_flit = '0;
    n_cmp++; if (o_tx_count !== 16'd1 || o_rx_count !== 16'd1) begin n_bad++; $display("FAIL rst_pre_counts: got tx=%0d rx=%0d want 1/1", o_tx_count, o_rx_count); end
    k = 0;
    while (!(o_flit.valid && o_flit.ftype == HEAD_FLIT) && k < 50) begin tick(); k++; end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL rst_second_head: got no head want head"); end
    tick();
    reset = 1'b1; i_start = 1'b0; i_send = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++; if (o_flit !== FLIT_t'('0) || o_transmit !== 1'b0) begin n_bad++; $display("FAIL rst_mid_outputs: got flit=%h req=%b want 0/0", o_flit, o_transmit); end
    n_cmp++; if (o_tx_count !== 16'd0 || o_rx_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid_counts: got tx=%0d rx=%0d want 0/0", o_tx_count, o_rx_count); end
    tick();
    n_cmp++; if (o_flit !== FLIT_t'('0)) begin n_bad++; $display("FAIL rst_mid_flushed: got %h want 0", o_flit); end
    i_body_len = 4'd1; i_num_pkts = 16'd1; i_dst_x = 8'd4; i_dst_y = 8'd4; i_send = 1'b1; i_start = 1'b1;
    collect(nb, fd, ld, hd, tl, hc, tc, tmo);
    exp = mk(HEAD_FLIT, 8'd4, 8'd4, 16'h0000, 16'h0000);
    n_cmp++; if (tmo !== 1'b0 || hd !== exp) begin n_bad++; $display("FAIL rst_rerun_head: got %h want %h", hd, exp); end
    n_cmp++; if (fd !== 16'h0000 || tl.reserved !== 16'h0000 || nb !== 1) begin n_bad++; $display("FAIL rst_rerun_seq: got body=%h tail=%h n=%0d want 0/0/1", fd, tl.reserved, nb); end
    tick();
    n_cmp++; if (o_tx_count !== 16'd1) begin n_bad++; $display("FAIL rst_rerun_count: got %0d want 1", o_tx_count); end
    i_start = 1'b0; i_send = 1'b0;
    tick();
    $display("reset_mid_send: rerun after reset sent seq %0d", tl.reserved);
  endtask

  initial begin
    test_reset();
    test_single();
    test_body_len();
    test_multi();
    test_abort_body();
    test_abort_send();
    test_rx();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_traffic_gen.md
# noc_traffic_gen

Parametrised network-interface traffic generator and checker for the mesh NoC, attached to one router local port. It builds packets with a programmable destination, body length, packet count and inter-packet gap, and stages each packet in an output FIFO. A request/grant handshake releases each packet to the router. An independent receive checker sinks incoming flits, counts complete packets and flags framing errors.

## Interface
Parameters:
- MAX_BODY, 8, maximum body flits per packet (≥1)
- FIFO_AW, 4, output FIFO address width; 2**FIFO_AW ≥ MAX_BODY+2 (elaboration-time assertion)
- BL_W, $clog2(MAX_BODY+1), body-length field width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  level enable; rising edge clears counters and error
- i_dst_x  in  8  destination x, latched at packet build start
- i_dst_y  in  8  destination y, latched at packet build start
- i_body_len  in  BL_W  body flits per packet; 0 treated as 1, >MAX_BODY clamped to MAX_BODY
- i_num_pkts  in  16  packets per run; 0 = continuous while i_start
- i_gap  in  8  idle cycles between packets
- o_flit  out  FLIT_t  outgoing flit, registered
- o_transmit  out  1  request to router, packet fully staged
- i_send  in  1  grant from router
- o_done  out  1  run complete
- o_tx_count  out  16  packets sent, wraps
- i_flit  in  FLIT_t  incoming flit
- i_rec_req  in  1  incoming flit valid
- o_rec_ack  out  1  tied 1; checker always sinks
- o_rx_count  out  16  complete packets received, wraps
- o_rx_err  out  1  sticky framing error

## Operation
- TX FSM states: IDLE, HEAD, BODY, TAIL, REQ, SEND, GAP, DONE.
- IDLE: on i_start=1, latch dst_x, dst_y and clamped body_len; go to HEAD.
- HEAD: write the head flit (valid=1, HEAD_FLIT, xaddr=dst_x, yaddr=dst_y). Go to BODY.
- BODY: write one body flit per cycle with data={seq[7:0], idx[7:0]}, where seq=o_tx_count[7:0] and idx starts at 0. Go to TAIL after body_len writes.
- TAIL: write the tail flit with reserved=seq (16 bits). Go to REQ.
- REQ: o_transmit=1. When i_send is sampled high, go to SEND.
- SEND: read the FIFO once per cycle until it is empty. When the tail is read, increment o_tx_count.
- After SEND: if i_num_pkts≠0 and o_tx_count==i_num_pkts, go to DONE. Otherwise go to GAP.
- GAP: wait i_gap cycles (0 = skip directly to HEAD), then go to HEAD.
- DONE: o_done=1. Hold until i_start=0, then go to IDLE.
- i_start=0 in HEAD/BODY/TAIL/REQ/GAP: abort, flush the FIFO, go to IDLE. No partial packet ever reaches o_flit.
- i_start=0 in SEND: finish draining the current packet, then go to IDLE.
- FIFO writes never see full; the depth assertion guarantees this.
- RX checker: two states, OUT and IN_PKT. Act only on i_rec_req & i_flit valid.
  - HEAD in OUT: go to IN_PKT.
  - BODY in IN_PKT: no state change.
  - TAIL in IN_PKT: increment o_rx_count, go to OUT.
  - Any other combination (BODY/TAIL in OUT, HEAD in IN_PKT): set o_rx_err. A HEAD in IN_PKT also starts a new packet.

## Timing
- Reset: all outputs 0, except o_rec_ack=1. Both FSMs go to IDLE/OUT; FIFO empty.
- Reset mid-operation: same as above, applied at the next clk edge; in-flight flits are discarded.
- Build phase: i_start sampled in cycle 0 → HEAD in cycle 1. o_transmit rises in cycle body_len+3.
- Send phase: i_send sampled in cycle t → head flit on o_flit in cycle t+2. Then body_len+1 further flits on consecutive cycles.
- o_flit is '0 on every cycle without a FIFO read, one cycle later (registered).
- o_tx_count increments on the cycle after the tail appears on o_flit. It compares against i_num_pkts in that same cycle.
- o_rx_count and o_rx_err update one cycle after the sampled flit.
- i_start rising edge: clears o_tx_count, o_rx_count and o_rx_err in the same cycle IDLE is left.

## Structure
- router_pkg holds FLIT_t, FLIT_TYPE_t, FLIT_SIZE and NUM_OF_FLITS. Add the TX_STATE_t and RX_STATE_t enums there.
- Sub-module: sfifo (existing), instantiated once as the output FIFO.
  - Width FLIT_SIZE, address width FIFO_AW.
  - rst_n = ~(reset | flush).
- The RX checker is inline; no input FIFO.

## Test plan
- body_len=2, num_pkts=1, dst=(1,0); grant 3 cycles after o_transmit → o_flit shows HEAD(1,0), BODY 0x0000, BODY 0x0001, TAIL 0x0000 on consecutive cycles; o_tx_count=1; o_done=1.
- body_len=0 and body_len=MAX_BODY+3 → exactly 1 and exactly MAX_BODY body flits respectively.
- num_pkts=3, gap=4, i_send held 1 → three packets with seq 0,1,2 in the body/tail fields; o_tx_count=3; DONE reached; o_done clears after i_start drops.
- i_start dropped during BODY → no flit on o_flit and FIFO empty. i_start dropped during SEND → full packet emitted, then IDLE.
- RX: HEAD, BODY, TAIL → o_rx_count=1, err=0. Then a lone TAIL → o_rx_err=1, sticky until an i_start rising edge.
- Assert reset mid-SEND → o_flit=0, o_transmit=0 and counters=0 on the next cycle; a subsequent run starts cleanly at seq 0.
